// File: rtl/p2s_pkg.sv
// Shared types and helpers for the parallel-to-serial shift-chain driver.
// Holds the FSM state encoding and counter sizing utilities.
package p2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        DONE
    } state_t;

    localparam int MIN_CW = 1;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int cnt_w(input int v);
        return (clog2(v) < MIN_CW) ? MIN_CW : clog2(v);
    endfunction

endpackage

// File: rtl/p2s_shift_driver_if.sv
// Bundle between a frame producer and one shift-chain driver.
// The producer owns the request side, the driver owns the chain pins.
interface p2s_shift_driver_if #(
    parameter int DATA_W = 64
);

    logic              start;
    logic [DATA_W-1:0] par_data;
    logic              lsb_first;
    logic              s_clk;
    logic              s_dout;
    logic              s_pen;
    logic              s_clrn;
    logic              busy;
    logic              done;

    modport master (
        output start, par_data, lsb_first,
        input  s_clk, s_dout, s_pen, s_clrn, busy, done
    );

    modport slave (
        input  start, par_data, lsb_first,
        output s_clk, s_dout, s_pen, s_clrn, busy, done
    );

endinterface

// File: rtl/p2s_phase_gen.sv
// Serial clock divider: DIV cycles low, DIV cycles high per bit.
// bit_end flags the last cycle of each high phase.
module p2s_phase_gen
    import p2s_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic phase,
    output logic bit_end
);

    localparam int DW = cnt_w(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          wrap;

    assign wrap    = (div_cnt == LAST);
    assign bit_end = run & phase & wrap;

    // Half-period counter; phase toggles on each wrap, parked low when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/p2s_shift_driver.sv
// Parallel-to-serial driver for an external shift-register chain.
// Shifts a captured frame out on a divided clock, then pulses the latch.
module p2s_shift_driver
    import p2s_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int DIV     = 2,
    parameter int LATCH_W = 2
) (
    input logic              clk,
    input logic              rst,
    p2s_shift_driver_if.slave bus
);

    localparam int BW = cnt_w(DATA_W + 1);
    localparam int LW = cnt_w(LATCH_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [LW-1:0] LAST_LAT = LW'(LATCH_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shnext;
    logic              mode;
    logic [BW-1:0]     bit_cnt;
    logic [LW-1:0]     lat_cnt;
    logic              run;
    logic              phase;
    logic              bit_end;
    logic              s_dout_q;
    logic              s_pen_q;
    logic              s_clrn_q;
    logic              busy_q;
    logic              done_q;

    assign run = (state == SHIFT);

    p2s_phase_gen #(
        .DIV(DIV)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .phase  (phase),
        .bit_end(bit_end)
    );

    // Next shift-register value; zero-filled in the direction of travel.
    always_comb begin
        shnext = shreg;
        if (mode) begin
            shnext = shreg >> 1;
        end else begin
            shnext = shreg << 1;
        end
    end

    // Frame sequencer: capture, shift, hold pen low, then latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            mode     <= 1'b0;
            bit_cnt  <= '0;
            lat_cnt  <= '0;
            s_dout_q <= 1'b0;
            s_pen_q  <= 1'b1;
            s_clrn_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            s_clrn_q <= 1'b1;
            done_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg    <= bus.par_data;
                        mode     <= bus.lsb_first;
                        s_dout_q <= bus.lsb_first ? bus.par_data[0]
                                                  : bus.par_data[DATA_W-1];
                        bit_cnt  <= '0;
                        state    <= SHIFT;
                        busy_q   <= 1'b1;
                        s_pen_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state    <= LATCH;
                            s_dout_q <= 1'b0;
                            lat_cnt  <= '0;
                        end else begin
                            shreg    <= shnext;
                            s_dout_q <= mode ? shnext[0] : shnext[DATA_W-1];
                        end
                    end
                end
                LATCH: begin
                    if (lat_cnt == LAST_LAT) begin
                        state   <= DONE;
                        s_pen_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_clk  = phase;
    assign bus.s_dout = s_dout_q;
    assign bus.s_pen  = s_pen_q;
    assign bus.s_clrn = s_clrn_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_p2s_shift_driver.sv
// Directed bench for p2s_shift_driver: 8-bit DIV=2 and 64-bit DIV=1 chains.
// Inputs change on the falling edge, outputs are sampled there too.
module tb_p2s_shift_driver;

    logic clk = 1'b0;
    logic rst8;
    logic rst64;

    always #5 clk = ~clk;

    p2s_shift_driver_if #(.DATA_W(8))  bus8 ();
    p2s_shift_driver_if #(.DATA_W(64)) bus64 ();

    p2s_shift_driver #(
        .DATA_W(8), .DIV(2), .LATCH_W(2)
    ) dut8 (
        .clk(clk), .rst(rst8), .bus(bus8)
    );

    p2s_shift_driver #(
        .DATA_W(64), .DIV(1), .LATCH_W(2)
    ) dut64 (
        .clk(clk), .rst(rst64), .bus(bus64)
    );

    int nvec = 0;
    int nbad = 0;
    bit use64 = 1'b0;

    wire m_sclk = use64 ? bus64.s_clk  : bus8.s_clk;
    wire m_dout = use64 ? bus64.s_dout : bus8.s_dout;
    wire m_pen  = use64 ? bus64.s_pen  : bus8.s_pen;
    wire m_clrn = use64 ? bus64.s_clrn : bus8.s_clrn;
    wire m_busy = use64 ? bus64.busy   : bus8.busy;
    wire m_done = use64 ? bus64.done   : bus8.done;

    typedef struct {
        logic [63:0] data;
        bit          lsb;
        int          chg_cyc;
        logic [63:0] chg_data;
        bit          chg_start;
        logic [63:0] exp_stream;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_start(input bit st);
        if (use64) bus64.start = st;
        else       bus8.start  = st;
    endtask

    task automatic set_in(input bit st, input logic [63:0] d, input bit lsb);
        set_start(st);
        if (use64) begin
            bus64.par_data  = d;
            bus64.lsb_first = lsb;
        end else begin
            bus8.par_data  = d[7:0];
            bus8.lsb_first = lsb;
        end
    endtask

    function automatic logic [63:0] rev64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = d[63-i];
        return r;
    endfunction

    // One frame: start, then watch every cycle until done or the bound.
    task automatic run_frame(
        input  logic [63:0] data,
        input  bit          lsb,
        input  int          chg_cyc,
        input  logic [63:0] chg_data,
        input  bit          chg_start,
        output logic [63:0] stream,
        output int          lat,
        output int          rises,
        output int          first_rise,
        output int          gap_err,
        output int          pen_low,
        output int          glitch,
        output bit          acc
    );
        int   div;
        int   last_rise;
        logic p_sclk;
        logic p_dout;
        div = use64 ? 1 : 2;
        stream = '0;
        lat = -1;
        rises = 0;
        first_rise = -1;
        gap_err = 0;
        pen_low = 0;
        glitch = 0;
        acc = 1'b0;
        last_rise = 0;
        @(negedge clk);
        p_sclk = m_sclk;
        p_dout = m_dout;
        set_in(1'b1, data, lsb);
        for (int c = 1; c <= 400 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                set_start(1'b0);
                acc = m_busy;
            end
            if (c == chg_cyc) set_in(chg_start, chg_data, ~lsb);
            if (c == chg_cyc + 1) set_start(1'b0);
            if (!m_pen) pen_low++;
            if (m_sclk && (m_dout !== p_dout)) glitch++;
            if (m_sclk && !p_sclk) begin
                stream = {stream[62:0], m_dout};
                if (rises == 0) first_rise = c;
                else if (c - last_rise != 2 * div) gap_err++;
                last_rise = c;
                rises++;
            end
            if (m_done) lat = c;
            p_sclk = m_sclk;
            p_dout = m_dout;
        end
    endtask

    logic [63:0] stream;
    logic [63:0] rd;
    int lat, rises, first_rise, gap_err, pen_low, glitch;
    int nd, lastd, wide, gaperr;
    bit acc, lsb, prevd;

    initial begin
        vt[0] = '{64'hA5, 1'b0, 0,  64'h00, 1'b0, 64'hA5};
        vt[1] = '{64'h81, 1'b1, 0,  64'h00, 1'b0, 64'h81};
        vt[2] = '{64'h01, 1'b1, 0,  64'h00, 1'b0, 64'h80};
        vt[3] = '{64'h0F, 1'b0, 13, 64'hF0, 1'b0, 64'h0F};
        vt[4] = '{64'h3C, 1'b1, 5,  64'hC3, 1'b1, 64'h3C};
        vt[5] = '{64'hC1, 1'b1, 0,  64'h00, 1'b0, 64'h83};
        vt[6] = '{64'h6E, 1'b0, 0,  64'h00, 1'b0, 64'h6E};

        rst8 = 1'b1;
        rst64 = 1'b1;
        bus8.start = 1'b0;
        bus8.par_data = '0;
        bus8.lsb_first = 1'b0;
        bus64.start = 1'b0;
        bus64.par_data = '0;
        bus64.lsb_first = 1'b0;

        // Reset values on both chains.
        #12;
        for (int u = 0; u < 2; u++) begin
            use64 = (u == 1);
            #1;
            chk("rst s_clk",  {63'd0, m_sclk}, 64'd0);
            chk("rst s_dout", {63'd0, m_dout}, 64'd0);
            chk("rst s_pen",  {63'd0, m_pen},  64'd1);
            chk("rst s_clrn", {63'd0, m_clrn}, 64'd0);
            chk("rst busy",   {63'd0, m_busy}, 64'd0);
            chk("rst done",   {63'd0, m_done}, 64'd0);
        end
        @(negedge clk);
        rst8 = 1'b0;
        rst64 = 1'b0;
        @(negedge clk);
        use64 = 1'b0;
        chk("clrn release 8", {63'd0, m_clrn}, 64'd1);
        use64 = 1'b1;
        chk("clrn release 64", {63'd0, m_clrn}, 64'd1);

        // Table of 8-bit frames.
        use64 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run_frame(vt[i].data, vt[i].lsb, vt[i].chg_cyc, vt[i].chg_data,
                      vt[i].chg_start, stream, lat, rises, first_rise,
                      gap_err, pen_low, glitch, acc);
            chk($sformatf("v%0d stream", i), {56'd0, stream[7:0]},
                vt[i].exp_stream);
            chk($sformatf("v%0d latency", i), 64'(lat), 64'd35);
            chk($sformatf("v%0d rises", i), 64'(rises), 64'd8);
            chk($sformatf("v%0d first rise", i), 64'(first_rise), 64'd3);
            chk($sformatf("v%0d rise gap", i), 64'(gap_err), 64'd0);
            chk($sformatf("v%0d pen low", i), 64'(pen_low), 64'd34);
            chk($sformatf("v%0d dout glitch", i), 64'(glitch), 64'd0);
            chk($sformatf("v%0d accepted", i), {63'd0, acc}, 64'd1);
            @(negedge clk);
            chk($sformatf("v%0d done width", i), {63'd0, m_done}, 64'd0);
            chk($sformatf("v%0d idle after", i), {63'd0, m_busy}, 64'd0);
        end

        // Start held high: one frame every 36 cycles, no queuing.
        @(negedge clk);
        set_in(1'b1, 64'hFF, 1'b0);
        nd = 0;
        lastd = -1;
        wide = 0;
        gaperr = 0;
        prevd = 1'b0;
        for (int c = 1; c <= 108; c++) begin
            @(negedge clk);
            if (m_done && prevd) wide++;
            if (m_done) begin
                if (lastd >= 0 && c - lastd != 36) gaperr++;
                lastd = c;
                nd++;
            end
            prevd = m_done;
        end
        set_start(1'b0);
        chk("held dones", 64'(nd), 64'd3);
        chk("held last done", 64'(lastd), 64'd107);
        chk("held period", 64'(gaperr), 64'd0);
        chk("held width", 64'(wide), 64'd0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_done) nd++;
        end
        chk("held no extra frame", 64'(nd), 64'd0);
        chk("held idle", {63'd0, m_busy}, 64'd0);

        // Reset in the middle of bit 5.
        @(negedge clk);
        set_in(1'b1, 64'h5A, 1'b0);
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1) set_start(1'b0);
        end
        chk("pre-rst busy", {63'd0, m_busy}, 64'd1);
        rst8 = 1'b1;
        #1;
        chk("mid rst s_clk", {63'd0, m_sclk}, 64'd0);
        chk("mid rst s_pen", {63'd0, m_pen}, 64'd1);
        chk("mid rst s_clrn", {63'd0, m_clrn}, 64'd0);
        chk("mid rst busy", {63'd0, m_busy}, 64'd0);
        @(negedge clk);
        rst8 = 1'b0;
        @(negedge clk);
        chk("post rst clrn", {63'd0, m_clrn}, 64'd1);
        nd = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (m_done || m_busy) nd++;
        end
        chk("post rst quiet", 64'(nd), 64'd0);
        run_frame(64'hA5, 1'b0, 0, 64'h0, 1'b0, stream, lat, rises,
                  first_rise, gap_err, pen_low, glitch, acc);
        chk("post rst stream", {56'd0, stream[7:0]}, 64'hA5);
        chk("post rst latency", 64'(lat), 64'd35);

        // 64-bit DIV=1 random frames, back to back.
        use64 = 1'b1;
        for (int f = 0; f < 20; f++) begin
            rd = {$urandom, $urandom};
            lsb = 1'($urandom_range(0, 1));
            run_frame(rd, lsb, 0, 64'h0, 1'b0, stream, lat, rises,
                      first_rise, gap_err, pen_low, glitch, acc);
            chk($sformatf("w%0d stream", f), stream, lsb ? rev64(rd) : rd);
            chk($sformatf("w%0d latency", f), 64'(lat), 64'd131);
            chk($sformatf("w%0d accepted", f), {63'd0, acc}, 64'd1);
            chk($sformatf("w%0d first rise", f), 64'(first_rise), 64'd2);
            chk($sformatf("w%0d rise gap", f), 64'(gap_err), 64'd0);
            chk($sformatf("w%0d pen low", f), 64'(pen_low), 64'd130);
            chk($sformatf("w%0d glitch", f), 64'(glitch), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/p2s_shift_driver.md
Name: p2s_shift_driver

Overview:
- Parametrised parallel-to-serial driver for the board's external shift-register chains (7-segment and LED banks).
- Captures a DATA_W-bit word on a start handshake and shifts it out MSB- or LSB-first on a divided serial clock.
- Issues a latch edge when shifting completes and reports done.
- One instance per chain; replaces the fixed-width, fixed-rate serial outputs of the previous display top.

Parameters:
DATA_W, 64, bits per frame (>=2)
DIV, 2, system cycles per serial-clock half period (>=1)
LATCH_W, 2, system cycles s_pen is held low after the last bit before the latch edge (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only while busy=0
par_data  input  DATA_W  frame to send; sampled on accepted start
lsb_first  input  1  0 = MSB first, 1 = LSB first; sampled on accepted start
s_clk  output  1  serial clock to shift-register chain
s_dout  output  1  serial data; changes only while s_clk=0
s_pen  output  1  latch/parallel enable; low while frame in flight, rising edge latches
s_clrn  output  1  active-low chain clear; 0 in reset, 1 from first clk edge after rst release
busy  output  1  frame in progress
done  output  1  one-cycle pulse, frame latched

Behaviour:
- Reset values:
  - s_clk=0, s_dout=0, s_pen=1, s_clrn=0, busy=0, done=0.
  - State IDLE; shift register, div counter and bit counter all 0.
- rst asserted mid-frame: immediate return to reset values. No partial latch edge is generated; s_pen goes straight to 1 asynchronously, and this is acceptable because the chain is cleared by s_clrn=0.
- All outputs are registered (no combinational paths from inputs).
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE:
  - busy=0, s_pen=1, s_clk=0.
  - start=1 at edge k: load shift reg with par_data; mode <- lsb_first.
  - At k+1: state SHIFT, busy=1, s_pen=0, s_dout = first bit (par_data[DATA_W-1] if MSB-first, par_data[0] if LSB-first).
- SHIFT:
  - Each bit occupies 2*DIV cycles: DIV cycles with s_clk=0, then DIV cycles with s_clk=1.
  - Rising s_clk occurs DIV cycles after s_dout changes; first rising edge at k+1+DIV.
  - At the end of each high phase, s_clk returns to 0 and the next bit is presented on s_dout in the same cycle.
  - The bit counter counts sent bits.
  - After bit DATA_W completes its high phase: state LATCH, s_clk=0, s_dout=0.
  - Total SHIFT duration = 2*DIV*DATA_W cycles.
- LATCH: s_pen=0, s_clk=0 held for LATCH_W cycles, then state DONE.
- DONE (one cycle):
  - s_pen=1 (rising edge latches chain), done=1, busy=1.
  - Next cycle: IDLE, busy=0, done=0.
- New start is accepted the first IDLE cycle after DONE.
- Start latency to done pulse: 1 + 2*DIV*DATA_W + LATCH_W cycles.
- start while busy=1: ignored, not queued.
- par_data/lsb_first changes while busy: no effect on the frame in flight.
- Counters:
  - div counter width clog2(DIV) (min 1), wraps at DIV-1.
  - bit counter width clog2(DATA_W+1); no overflow possible.
- Shift register shifts left (MSB-first) or right (LSB-first), zero-filling.

Decomposition:
- Shared package p2s_pkg:
  - state enum {IDLE, SHIFT, LATCH, DONE}
  - clog2 helper function
  - localparam for minimum counter width 1
- One sub-module, p2s_phase_gen: the DIV divider.
  - Inputs: clk, rst, run.
  - Outputs: phase (s_clk level) and a bit_end tick at the end of each high phase.
  - The main FSM consumes bit_end.

Test Plan:
- DATA_W=8, DIV=2, LATCH_W=2, par_data=8'hA5, lsb_first=0, start pulse:
  - bits sampled on each s_clk rise = 1,0,1,0,0,1,0,1.
  - 8 rising edges, 4 cycles apart.
  - done exactly 1+32+2=35 cycles after start edge.
  - s_pen low for 34 cycles then high.
- Same config, lsb_first=1, par_data=8'h81 then 8'h01:
  - captured streams 1,0,0,0,0,0,0,1 and 1,0,0,0,0,0,0,0.
  - s_dout never changes while s_clk=1.
- start held high continuously with par_data=8'hFF:
  - one frame per 36 cycles (35 + IDLE cycle).
  - done pulses exactly one cycle wide.
  - start during busy is not queued.
- Change par_data from 8'h0F to 8'hF0 at bit 3 of a frame: received byte is still 8'h0F.
- Assert rst for 1 cycle at bit 5:
  - same cycle: s_clk=0, s_pen=1, s_clrn=0, busy=0.
  - no done pulse.
  - after release, s_clrn=1 next edge; a fresh start sends a full correct frame.
- DATA_W=64, DIV=1, random data (20 frames):
  - scoreboard matches every frame.
  - done-to-start gap of 1 cycle honoured.
